dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the pipelined core: it serves the load/store requests the MEM stage issues, using a valid/ready request channel and a valid/ready response channel. One request is outstanding at a time. Each access takes a programmable number of wait states. The block performs byte/halfword/word store lane-merging and load sign/zero extension, and it flags out-of-range accesses (and, optionally, misaligned ones) on the response.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two.
- WAIT_CYCLES, 1: wait states between accept and response, range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- req_size  in  2  access size: 00 word, 01 halfword, 10 byte, 11 illegal.
- req_lu  in  1  load unsigned (zero-extend); ignored for word loads and stores.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  access rejected; no memory change.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1.
    - On req_valid & req_ready, capture addr/we/wdata/size/lu.
    - Load counter with WAIT_CYCLES.
    - Go to WAIT, or directly to RESP if WAIT_CYCLES=0.
  - WAIT: req_ready=0.
    - Decrement counter each cycle.
    - When the counter reaches 0, perform the access and go to RESP.
  - RESP: rsp_valid=1.
    - rsp_rdata/rsp_err are held stable.
    - On rsp_ready, return to IDLE.
- Access is performed on the edge entering RESP.
  - Stores commit to the array on that edge.
  - Loads latch rsp_rdata on that edge.
- Word index is req_addr[log2(DEPTH_WORDS)+1:2]. If req_addr[31:log2(DEPTH_WORDS)+2] is nonzero, the access is out of range: rsp_err=1, no write, rdata 0.
- req_size=11 always gives rsp_err=1, no write.
- Store lane merge (read-modify-write of one word):
  - byte: lane addr[1:0] receives wdata[7:0].
  - half: lane addr[1] receives wdata[15:0].
  - word: full word.
- Load extract:
  - byte: lane addr[1:0], extended from bit 7.
  - half: lane addr[1], extended from bit 15.
  - Extension is zero-extension if req_lu=1, sign-extension otherwise.
- Array contents are not cleared by reset; contents are undefined until written.
- Reset mid-operation: the FSM returns to IDLE and the captured request is discarded. A store not yet committed never reaches the array.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE, counter 0.
- A request accepted at rising edge k produces rsp_valid=1 from edge k+1+WAIT_CYCLES.
- rsp_valid stays high until the edge where rsp_ready=1 is sampled. The next request can be accepted no earlier than the following edge, so the minimum issue interval is WAIT_CYCLES+2 cycles.
- rsp_ready asserted before rsp_valid has no effect.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- A back-to-back store then load to the same word returns the stored data, because the store commits before the load is accepted.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, is rejected: rsp_err=1, rdata 0, no write.
- DMEM_MISALIGN_TRAP_EN undefined:
  - No misalignment check.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. The access proceeds on the aligned lane/word.
  - rsp_err arises only from the range and size checks.

## Test plan
- Reset, WAIT_CYCLES=1:
  - Word store 0xDEADBEEF to 0x10, accepted at edge k → rsp_valid at edge k+2, rsp_err=0, rdata 0.
  - Then word load 0x10 → rdata 0xDEADBEEF.
- After the 0xDEADBEEF store:
  - Byte store 0x7F to 0x13 (word becomes 0x7FADBEEF); load word 0x10 → 0x7FADBEEF.
  - Signed byte load 0x12 → 0xFFFFFFAD; unsigned → 0x000000AD.
  - Signed half load 0x12 → 0x00007FAD.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_rdata, rsp_err stable and req_ready=0 throughout. Release rsp_ready → IDLE next edge.
- Errors:
  - Load at DEPTH_WORDS*4 → rsp_err=1, rdata 0.
  - Store with req_size=11 → rsp_err=1; a later read shows the word unchanged.
  - With DMEM_MISALIGN_TRAP_EN: half load at 0x11 → rsp_err=1.
  - Without it: the same load returns the half at lane 0, rsp_err=0.
- Reset during WAIT of a word store of 0x12345678 over 0 → next load of that word returns 0, and the FSM accepts immediately after reset.
- WAIT_CYCLES=0 build: accept at edge k → rsp_valid at edge k+1; with rsp_ready held 1, requests accepted every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-outstanding data-memory responder with programmable wait
//            states, store lane merge, load extension and range/size checks.
//            Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_lu_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int         C_AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        lu_q, lu_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request rather than the captured copy.
  logic        w_direct;
  logic [31:0] w_addr, w_wdata;
  logic        w_we, w_lu;
  logic [1:0]  w_size;
  logic [C_AW-1:0] w_idx;
  logic [31:0] w_word, w_load, w_merge;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [4:0]  w_bsh, w_hsh;
  logic        w_oor, w_mis, w_err, w_access;

  assign w_direct = (state_q == S_IDLE);
  assign w_addr   = w_direct ? req_addr_i  : addr_q;
  assign w_wdata  = w_direct ? req_wdata_i : wdata_q;
  assign w_we     = w_direct ? req_we_i    : we_q;
  assign w_lu     = w_direct ? req_lu_i    : lu_q;
  assign w_size   = w_direct ? req_size_i  : size_q;

  assign w_idx  = w_addr[C_AW+1:2];
  assign w_word = mem_q[w_idx];
  assign w_bsh  = {w_addr[1:0], 3'b000};
  assign w_hsh  = {w_addr[1], 4'b0000};
  assign w_half = w_word[w_hsh +: 16];
  assign w_byte = w_word[w_bsh +: 8];
  assign w_oor  = |(w_addr >> (C_AW + 2));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = ((w_size == 2'b01) && w_addr[0]) ||
                 ((w_size == 2'b00) && (w_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_err    = w_oor || (w_size == 2'b11) || w_mis;
  assign w_access = ((state_q == S_IDLE) && req_valid_i && (C_WAIT == 4'd0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd1));

  always_comb begin
    w_load  = w_word;
    w_merge = w_wdata;
    case (w_size)
      2'b01: begin
        w_load  = {{16{w_half[15] & ~w_lu}}, w_half};
        w_merge = w_word;
        w_merge[w_hsh +: 16] = w_wdata[15:0];
      end
      2'b10: begin
        w_load  = {{24{w_byte[7] & ~w_lu}}, w_byte};
        w_merge = w_word;
        w_merge[w_bsh +: 8] = w_wdata[7:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    lu_d        = lu_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          we_d    = req_we_i;
          size_d  = req_size_i;
          lu_d    = req_lu_i;
          cnt_d   = C_WAIT;
          state_d = (C_WAIT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (w_access) begin
      err_d   = w_err;
      rdata_d = (w_err || w_we) ? 32'h0 : w_load;
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      lu_q    <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      lu_q    <= lu_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; a reset edge must still suppress a pending commit.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_access && w_we && !w_err) mem_q[w_idx] <= w_merge;
  end
endmodule
`default_nettype wire
